// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter sharing one synchronous FIFO among NREQ
// producers. Each producer offers a beat with req[i] and data[i]. The beat transfers on the
// rising edge where req[i] & ack[i] are both high. The winning beat is then presented to the
// FIFO as a registered write one cycle later.
//
// Admission counts the write already in flight on top of fifo_count, so the FIFO cannot
// overflow.
//
// Optional feature: define FIFO_ARB_BURST_EN to let a winner keep the grant for up to
// MAX_BURST consecutive beats (IDLE <-> LOCK FSM). If it is undefined, the grant rotates
// after every beat.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req, data    per-producer valid and packed data (slice i = data[i*DW +: DW])
//   ack          combinational one-hot grant; a beat moves when req[i] & ack[i]
//   fifo_count   FIFO occupancy, 0..DEPTH
//   fifo_wt_en   registered FIFO write strobe
//   fifo_din     registered FIFO write data
//   last_id      requester id of the most recently transferred beat
//   wr_total     16-bit transferred-beat counter (wraps)
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned CW       = $clog2(DEPTH) + 1,
  localparam int unsigned IW       = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ack,
  input  logic [CW-1:0]      fifo_count,
  output logic               fifo_wt_en,
  output logic [DW-1:0]      fifo_din,
  output logic [IW-1:0]      last_id,
  output logic [15:0]        wr_total
);

  if (NREQ < 2 || MAX_BURST < 1) begin : g_param_err
    $error("fifo_wr_arbiter: NREQ must be >= 2 and MAX_BURST >= 1");
  end

  localparam logic [NREQ-1:0] AckBit0 = NREQ'(1);

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
  endfunction

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] win_id, gnt_id;
  logic          win_vld, gnt_vld;
  logic [CW:0]   occupancy;
  logic          can_issue;
  logic          xfer;

  // The write in flight has not reached fifo_count yet, so count it as a claimed slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_wt_en};
  assign can_issue = occupancy < (CW+1)'(DEPTH);

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win_id  = rr_ptr_q;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

  // While locked, only the owner is eligible; the lock is kept through stalls.
  always_comb begin
    if (state_q == StLock) begin
      gnt_id  = owner_q;
      gnt_vld = req[owner_q];
    end else begin
      gnt_id  = win_id;
      gnt_vld = win_vld;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = next_id(win_id);
          end else begin
            state_d     = StLock;
            owner_d     = win_id;
            burst_cnt_d = BCW'(1);
          end
        end
      end
      StLock: begin
        if (!req[owner_q] || (xfer && burst_cnt_q == BCW'(MAX_BURST - 1))) begin
          state_d     = StIdle;
          rr_ptr_d    = next_id(owner_q);
          burst_cnt_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign gnt_id  = win_id;
  assign gnt_vld = win_vld;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = next_id(win_id);
    end
  end
`endif

  assign xfer = gnt_vld && can_issue;
  assign ack  = (xfer && rst_n) ? (AckBit0 << gnt_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      fifo_wt_en <= 1'b0;
      fifo_din   <= '0;
      last_id    <= '0;
      wr_total   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fifo_wt_en <= xfer;
      if (xfer) begin
        fifo_din <= data[gnt_id*DW +: DW];
        last_id  <= gnt_id;
        wr_total <= wr_total + 16'd1;
      end
    end
  end

endmodule
